count_seq_checker: RTL and testbench

//  Downstream consumer of the 4-bit JK up-counter output (Count).

---
 rtl/count_chk_pkg.sv | 11 +
 rtl/sat_counter.sv | 32 +++
 rtl/count_seq_checker.sv | 168 ++++++++++++++++
 tb/tb_count_seq_checker.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/count_chk_pkg.sv
// Shared types and default widths for the count sequence checker.
package count_chk_pkg;

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} chk_state_t;

  localparam int unsigned DefCntW  = 4;
  localparam int unsigned DefLockN = 2;
  localparam int unsigned DefWrapW = 8;
  localparam int unsigned DefErrW  = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear is applied before the increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d, base;

  always_comb begin
    base = clr ? '0 : q_q;
    q_d  = base;
    if (inc && (base != '1)) begin
      q_d = base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a free-running up-counter for +1 mod 2^CNT_W steps, with lock, wrap and error status.
// Optional first-error capture ports are enabled by defining COUNT_CHK_CAPTURE_EN.
module count_seq_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned LOCK_N = DefLockN,
  parameter int unsigned WRAP_W = DefWrapW,
  parameter int unsigned ERR_W  = DefErrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  count_in,
  output logic              locked,
  output logic              wrap_pulse,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt
`ifdef COUNT_CHK_CAPTURE_EN
  ,
  output logic              cap_valid,
  output logic [CNT_W-1:0]  cap_exp,
  output logic [CNT_W-1:0]  cap_act
`endif
);

  localparam logic [3:0] LockN = 4'(LOCK_N);

  chk_state_t       state_q, state_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [3:0]       good_q, good_d;
  logic             locked_q, locked_d;
  logic             wrap_pulse_q, err_pulse_q;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] exp_next;
  logic             step_ok;
  logic             wrap_ev, err_ev;

  assign exp_next = CNT_W'(prev_q + 1'b1);
  assign step_ok  = (count_in == exp_next);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    wrap_ev = 1'b0;
    err_ev  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          prev_d  = count_in;
          good_d  = '0;
        end
        ACQUIRE: begin
          prev_d = count_in;
          if (step_ok) begin
            good_d = good_q + 1'b1;
            if (good_d == LockN) begin
              state_d = TRACK;
            end
          end else begin
            good_d = '0;
          end
        end
        TRACK: begin
          prev_d = count_in;
          if (step_ok) begin
            // Only a correct step into zero counts as a wrap
            wrap_ev = (count_in == '0);
          end else begin
            err_ev  = 1'b1;
            good_d  = '0;
            state_d = ACQUIRE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    locked_d     = (state_d == TRACK);
    err_sticky_d = (clear ? 1'b0 : err_sticky_q) | err_ev;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      good_q       <= '0;
      locked_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      good_q       <= good_d;
      locked_q     <= locked_d;
      wrap_pulse_q <= wrap_ev;
      err_pulse_q  <= err_ev;
      err_sticky_q <= err_sticky_d;
    end
  end

  sat_counter #(
    .W (WRAP_W)
  ) u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (wrap_ev),
    .q     (wrap_cnt)
  );

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (err_ev),
    .q     (err_cnt)
  );

  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;

`ifdef COUNT_CHK_CAPTURE_EN
  logic             cap_valid_q, cap_valid_d;
  logic [CNT_W-1:0] cap_exp_q, cap_exp_d;
  logic [CNT_W-1:0] cap_act_q, cap_act_d;

  always_comb begin
    cap_valid_d = clear ? 1'b0 : cap_valid_q;
    cap_exp_d   = clear ? '0 : cap_exp_q;
    cap_act_d   = clear ? '0 : cap_act_q;
    // Keep the first error only; a same-edge clear re-arms the capture
    if (err_ev && !cap_valid_d) begin
      cap_valid_d = 1'b1;
      cap_exp_d   = exp_next;
      cap_act_d   = count_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_valid_q <= 1'b0;
      cap_exp_q   <= '0;
      cap_act_q   <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_exp_q   <= cap_exp_d;
      cap_act_q   <= cap_act_d;
    end
  end

  assign cap_valid = cap_valid_q;
  assign cap_exp   = cap_exp_q;
  assign cap_act   = cap_act_q;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed-vector bench for count_seq_checker (CNT_W=4, LOCK_N=2, ERR_W=2).
module tb_count_seq_checker;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       clear;
  logic [3:0] count_in;
  logic       locked, wrap_pulse, err_pulse, err_sticky;
  logic [7:0] wrap_cnt;
  logic [1:0] err_cnt;
`ifdef COUNT_CHK_CAPTURE_EN
  logic       cap_valid;
  logic [3:0] cap_exp, cap_act;
`endif

  int checks   = 0;
  int failures = 0;

  count_seq_checker #(
    .CNT_W  (4),
    .LOCK_N (2),
    .WRAP_W (8),
    .ERR_W  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .count_in   (count_in),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .wrap_cnt   (wrap_cnt),
    .err_cnt    (err_cnt)
`ifdef COUNT_CHK_CAPTURE_EN
    ,
    .cap_valid  (cap_valid),
    .cap_exp    (cap_exp),
    .cap_act    (cap_act)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] cnt;
    logic       lk;
    logic       wp;
    logic       ep;
    logic       st;
    logic [7:0] wc;
    logic [1:0] ec;
    logic       cv;
    logic [3:0] ce;
    logic [3:0] ca;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic en, input logic clr, input logic [3:0] cnt,
                   input logic lk, input logic wp, input logic ep, input logic st,
                   input logic [7:0] wc, input logic [1:0] ec,
                   input logic cv, input logic [3:0] ce, input logic [3:0] ca);
    vec_t r;
    r.en = en; r.clr = clr; r.cnt = cnt;
    r.lk = lk; r.wp = wp; r.ep = ep; r.st = st; r.wc = wc; r.ec = ec;
    r.cv = cv; r.ce = ce; r.ca = ca;
    vecs.push_back(r);
  endtask

  task automatic check_out(input string name, input vec_t e);
    logic [13:0] act, exp;
    act = {locked, wrap_pulse, err_pulse, err_sticky, wrap_cnt, err_cnt};
    exp = {e.lk, e.wp, e.ep, e.st, e.wc, e.ec};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got lk=%b wp=%b ep=%b st=%b wc=%0d ec=%0d, want lk=%b wp=%b ep=%b st=%b wc=%0d ec=%0d",
               name, locked, wrap_pulse, err_pulse, err_sticky, wrap_cnt, err_cnt,
               e.lk, e.wp, e.ep, e.st, e.wc, e.ec);
    end
`ifdef COUNT_CHK_CAPTURE_EN
    checks++;
    if ({cap_valid, cap_exp, cap_act} !== {e.cv, e.ce, e.ca}) begin
      failures++;
      $display("FAIL %s capture: got v=%b e=%0d a=%0d, want v=%b e=%0d a=%0d",
               name, cap_valid, cap_exp, cap_act, e.cv, e.ce, e.ca);
    end
`endif
  endtask

  vec_t zero_v;

  initial begin
    zero_v = '{en: 1'b0, clr: 1'b0, cnt: 4'd0, lk: 1'b0, wp: 1'b0, ep: 1'b0, st: 1'b0,
               wc: 8'd0, ec: 2'd0, cv: 1'b0, ce: 4'd0, ca: 4'd0};

    // Count 0..15,0 into lock and first wrap
    v(1,0,0,  0,0,0,0, 0,0, 0,0,0);
    v(1,0,1,  0,0,0,0, 0,0, 0,0,0);
    for (int i = 2; i < 16; i++) v(1,0,4'(i), 1,0,0,0, 0,0, 0,0,0);
    v(1,0,0,  1,1,0,0, 1,0, 0,0,0);
    // Error at 8, relock at 10
    for (int i = 1; i < 7; i++) v(1,0,4'(i), 1,0,0,0, 1,0, 0,0,0);
    v(1,0,8,  0,0,1,1, 1,1, 1,7,8);
    v(1,0,9,  0,0,0,1, 1,1, 1,7,8);
    v(1,0,10, 1,0,0,1, 1,1, 1,7,8);
    // Five errors, err_cnt saturates at 3; error into 0 is not a wrap
    v(1,0,0,  0,0,1,1, 1,2, 1,7,8);
    v(1,0,1,  0,0,0,1, 1,2, 1,7,8);
    v(1,0,2,  1,0,0,1, 1,2, 1,7,8);
    v(1,0,15, 0,0,1,1, 1,3, 1,7,8);
    v(1,0,0,  0,0,0,1, 1,3, 1,7,8);
    v(1,0,1,  1,0,0,1, 1,3, 1,7,8);
    v(1,0,7,  0,0,1,1, 1,3, 1,7,8);
    v(1,0,8,  0,0,0,1, 1,3, 1,7,8);
    v(1,0,9,  1,0,0,1, 1,3, 1,7,8);
    v(1,0,3,  0,0,1,1, 1,3, 1,7,8);
    v(1,0,4,  0,0,0,1, 1,3, 1,7,8);
    v(1,0,5,  1,0,0,1, 1,3, 1,7,8);
    v(1,0,12, 0,0,1,1, 1,3, 1,7,8);
    v(1,0,13, 0,0,0,1, 1,3, 1,7,8);
    v(1,0,14, 1,0,0,1, 1,3, 1,7,8);
    // Clear with error, relock, clear alone, clear with wrap
    v(1,1,9,  0,0,1,1, 0,1, 1,15,9);
    v(1,0,10, 0,0,0,1, 0,1, 1,15,9);
    v(1,0,11, 1,0,0,1, 0,1, 1,15,9);
    v(1,1,12, 1,0,0,0, 0,0, 0,0,0);
    v(1,0,13, 1,0,0,0, 0,0, 0,0,0);
    v(1,0,14, 1,0,0,0, 0,0, 0,0,0);
    v(1,0,15, 1,0,0,0, 0,0, 0,0,0);
    v(1,1,0,  1,1,0,0, 1,0, 0,0,0);
    v(1,0,1,  1,0,0,0, 1,0, 0,0,0);
    // Disable drops to IDLE, counters hold; re-enable reacquires
    v(0,0,2,  0,0,0,0, 1,0, 0,0,0);
    v(0,0,5,  0,0,0,0, 1,0, 0,0,0);
    v(1,0,3,  0,0,0,0, 1,0, 0,0,0);
    v(1,0,4,  0,0,0,0, 1,0, 0,0,0);
    v(1,0,5,  1,0,0,0, 1,0, 0,0,0);

    reset    = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    count_in = 4'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_out("reset", zero_v);
      count_in = count_in + 4'd1;
    end
    reset    = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      enable   = vecs[i].en;
      clear    = vecs[i].clr;
      count_in = vecs[i].cnt;
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while locked clears everything, then reacquire starts from scratch
    reset    = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    count_in = 4'd6;
    @(posedge clk); #1;
    check_out("reset_mid_track", zero_v);
    reset    = 1'b1;
    count_in = 4'd0;
    @(posedge clk); #1;
    check_out("post_reset_acq", zero_v);
    count_in = 4'd1;
    @(posedge clk); #1;
    check_out("post_reset_good1", zero_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
